// File: rtl/register_file.sv
// MIPS general-purpose register file.
// Two combinational read ports with write-through bypass, one synchronous
// write port, and a debug dump sequencer that streams every register out
// over a valid/ready handshake.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  // writeback stage
  input  logic                  i_regwrite,
  input  logic [ADDR_WIDTH-1:0] i_write_addr,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  // decode stage
  input  logic [ADDR_WIDTH-1:0] i_read_addr_a,
  input  logic [ADDR_WIDTH-1:0] i_read_addr_b,
  output logic [DATA_WIDTH-1:0] o_data_a,
  output logic [DATA_WIDTH-1:0] o_data_b,
  // debug dump
  input  logic                  i_dump_start,
  input  logic                  i_dump_ready,
  output logic                  o_dump_valid,
  output logic [ADDR_WIDTH-1:0] o_dump_addr,
  output logic [DATA_WIDTH-1:0] o_dump_data,
  output logic                  o_dump_done
);

  localparam int                    NUM_REGS  = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DONE
  } dump_state_t;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  dump_state_t           dump_state;
  logic [ADDR_WIDTH-1:0] next_dump_addr;
  logic [DATA_WIDTH-1:0] next_dump_data;
  logic                  write_en;

  // Writes to r0 are dropped so r0 storage stays at its reset value.
  assign write_en = i_regwrite && (i_write_addr != '0);

  // Register storage: cleared on reset, written by the writeback stage.
  // NOTE: this array is reset because a debug dump must report zeros after
  // reset; a plain RAM without reset would map to denser memory cells.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      regs <= '{default: '0};
    end else if (write_en) begin
      // NOTE: non-blocking so every read in this edge sees pre-edge state.
      regs[i_write_addr] <= i_write_data;
    end
  end

  // Read port A: r0 is hard zero, then same-cycle write bypass, then storage.
  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    o_data_a = regs[i_read_addr_a];
    if (i_read_addr_a == '0) begin
      o_data_a = '0;
    end else if (i_regwrite && (i_write_addr == i_read_addr_a)) begin
      o_data_a = i_write_data;
    end
  end

  // Read port B: same priority as port A.
  always_comb begin
    o_data_b = regs[i_read_addr_b];
    if (i_read_addr_b == '0) begin
      o_data_b = '0;
    end else if (i_regwrite && (i_write_addr == i_read_addr_b)) begin
      o_data_b = i_write_data;
    end
  end

  // Value of the register the dump presents next, with write bypass so a
  // write landing on the advancing edge is not missed.
  always_comb begin
    next_dump_addr = o_dump_addr + 1'b1;
    next_dump_data = regs[next_dump_addr];
    if (next_dump_addr == '0) begin
      next_dump_data = '0;
    end else if (i_regwrite && (i_write_addr == next_dump_addr)) begin
      next_dump_data = i_write_data;
    end
  end

  // Dump sequencer: walks r0..rN-1, holding the presented word while the
  // consumer stalls, then pulses done for one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dump_state   <= ST_IDLE;
      o_dump_valid <= 1'b0;
      o_dump_done  <= 1'b0;
      o_dump_addr  <= '0;
      o_dump_data  <= '0;
    end else begin
      case (dump_state)
        ST_IDLE: begin
          o_dump_done <= 1'b0;
          if (i_dump_start) begin
            dump_state   <= ST_SEND;
            o_dump_valid <= 1'b1;
            o_dump_addr  <= '0;
            o_dump_data  <= '0;
          end
        end
        ST_SEND: begin
          if (i_dump_ready) begin
            if (o_dump_addr == LAST_ADDR) begin
              dump_state   <= ST_DONE;
              o_dump_valid <= 1'b0;
              o_dump_done  <= 1'b1;
            end else begin
              o_dump_addr <= next_dump_addr;
              o_dump_data <= next_dump_data;
            end
          end
        end
        ST_DONE: begin
          dump_state  <= ST_IDLE;
          o_dump_done <= 1'b0;
        end
        default: begin
          dump_state   <= ST_IDLE;
          o_dump_valid <= 1'b0;
          o_dump_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed table vectors, hand-written
// dump sequences and a randomized phase, all checked against a behavioural
// model of the register contents and the dump word stream.
module tb_register_file;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_regwrite = 1'b0;
  logic [AW-1:0] i_write_addr = '0;
  logic [DW-1:0] i_write_data = '0;
  logic [AW-1:0] i_read_addr_a = '0;
  logic [AW-1:0] i_read_addr_b = '0;
  logic [DW-1:0] o_data_a;
  logic [DW-1:0] o_data_b;
  logic          i_dump_start = 1'b0;
  logic          i_dump_ready = 1'b0;
  logic          o_dump_valid;
  logic [AW-1:0] o_dump_addr;
  logic [DW-1:0] o_dump_data;
  logic          o_dump_done;

  int n_checks = 0;
  int n_errors = 0;

  register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_regwrite   (i_regwrite),
    .i_write_addr (i_write_addr),
    .i_write_data (i_write_data),
    .i_read_addr_a(i_read_addr_a),
    .i_read_addr_b(i_read_addr_b),
    .o_data_a     (o_data_a),
    .o_data_b     (o_data_b),
    .i_dump_start (i_dump_start),
    .i_dump_ready (i_dump_ready),
    .o_dump_valid (o_dump_valid),
    .o_dump_addr  (o_dump_addr),
    .o_dump_data  (o_dump_data),
    .o_dump_done  (o_dump_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model. Registers are a plain array; the dump is described as
  // a stream: word 0 is always zero, and word k (k>0) carries register k as
  // it stands right after the edge that accepted word k-1.
  // ---------------------------------------------------------------------
  localparam int PH_IDLE = 0;
  localparam int PH_SEND = 1;
  localparam int PH_DONE = 2;

  logic [DW-1:0] m_regs [NREG];
  logic [DW-1:0] m_post [NREG];
  int            m_phase = PH_IDLE;
  int            m_idx   = 0;
  logic [DW-1:0] m_word  = '0;
  logic [DW-1:0] m_exp_a;
  logic [DW-1:0] m_exp_b;

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] addr);
    if (addr == 0) return '0;
    if (i_regwrite && i_write_addr == addr) return i_write_data;
    return m_regs[addr];
  endfunction

  // Checked on the falling edge, where inputs and registered outputs are
  // stable; then advances the model to the state after the next rising edge.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) m_regs[i] = '0;
      m_phase = PH_IDLE;
      m_idx   = 0;
      m_word  = '0;
      check("mon_rst_valid", 64'(o_dump_valid), 64'd0);
      check("mon_rst_done",  64'(o_dump_done),  64'd0);
      check("mon_rst_addr",  64'(o_dump_addr),  64'd0);
      check("mon_rst_data",  64'(o_dump_data),  64'd0);
    end else begin
      m_exp_a = model_read(i_read_addr_a);
      m_exp_b = model_read(i_read_addr_b);
      check("mon_read_a", 64'(o_data_a), 64'(m_exp_a));
      check("mon_read_b", 64'(o_data_b), 64'(m_exp_b));
      check("mon_dump_valid", 64'(o_dump_valid), 64'(m_phase == PH_SEND));
      check("mon_dump_done",  64'(o_dump_done),  64'(m_phase == PH_DONE));
      if (m_phase == PH_SEND) begin
        check("mon_dump_addr", 64'(o_dump_addr), 64'(m_idx));
        check("mon_dump_data", 64'(o_dump_data), 64'(m_word));
      end
      m_post = m_regs;
      if (i_regwrite && i_write_addr != 0) m_post[i_write_addr] = i_write_data;
      case (m_phase)
        PH_IDLE: if (i_dump_start) begin
          m_phase = PH_SEND;
          m_idx   = 0;
          m_word  = '0;
        end
        PH_SEND: if (i_dump_ready) begin
          if (m_idx == NREG - 1) begin
            m_phase = PH_DONE;
          end else begin
            m_idx  = m_idx + 1;
            m_word = m_post[m_idx];
          end
        end
        default: m_phase = PH_IDLE;
      endcase
      m_regs = m_post;
    end
  end

  // ---------------------------------------------------------------------
  // Directed vector table for the read/write/bypass paths.
  // ---------------------------------------------------------------------
  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
  } vec_t;

  vec_t vecs [10];
  int   cyc;
  int   k;
  int   n;

  initial begin
    vecs[0] = '{1'b1, 5'd0,  32'hDEADBEEF, 5'd0,  5'd0,  32'h0,        32'h0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
    vecs[2] = '{1'b1, 5'd5,  32'h12345678, 5'd5,  5'd0,  32'h12345678, 32'h0};
    vecs[3] = '{1'b0, 5'd5,  32'h0,        5'd5,  5'd5,  32'h12345678, 32'h12345678};
    vecs[4] = '{1'b1, 5'd6,  32'hCAFEF00D, 5'd5,  5'd6,  32'h12345678, 32'hCAFEF00D};
    vecs[5] = '{1'b1, 5'd5,  32'h0BADC0DE, 5'd5,  5'd6,  32'h0BADC0DE, 32'hCAFEF00D};
    vecs[6] = '{1'b0, 5'd5,  32'h0,        5'd5,  5'd6,  32'h0BADC0DE, 32'hCAFEF00D};
    vecs[7] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd30, 32'hFFFFFFFF, 32'h0};
    vecs[8] = '{1'b0, 5'd31, 32'h0,        5'd31, 5'd0,  32'hFFFFFFFF, 32'h0};
    vecs[9] = '{1'b0, 5'd7,  32'h11111111, 5'd7,  5'd7,  32'h0,        32'h0};

    // Reset: every address reads zero, dump outputs idle.
    repeat (2) tick();
    for (int a = 0; a < NREG; a++) begin
      i_read_addr_a = AW'(a);
      i_read_addr_b = AW'(NREG - 1 - a);
      #1;
      check("rst_read_a", 64'(o_data_a), 64'd0);
      check("rst_read_b", 64'(o_data_b), 64'd0);
    end
    check("rst_dump_valid", 64'(o_dump_valid), 64'd0);
    check("rst_dump_done",  64'(o_dump_done),  64'd0);
    tick();
    i_rst_n = 1'b1;
    tick();

    // Table-driven read/write/bypass vectors.
    for (int v = 0; v < 10; v++) begin
      i_regwrite    = vecs[v].we;
      i_write_addr  = vecs[v].wa;
      i_write_data  = vecs[v].wd;
      i_read_addr_a = vecs[v].ra;
      i_read_addr_b = vecs[v].rb;
      #1;
      check("vec_data_a", 64'(o_data_a), 64'(vecs[v].ea));
      check("vec_data_b", 64'(o_data_b), 64'(vecs[v].eb));
      tick();
    end

    // Load r_i = i*0x11.
    for (int i = 1; i < NREG; i++) begin
      i_regwrite   = 1'b1;
      i_write_addr = AW'(i);
      i_write_data = DW'(i * 32'h11);
      tick();
    end
    i_regwrite = 1'b0;
    tick();

    // Full-speed dump: 32 consecutive words, done in cycle N+33.
    i_dump_start = 1'b1;
    i_dump_ready = 1'b1;
    tick();
    i_dump_start = 1'b0;
    for (int w = 0; w < NREG; w++) begin
      #1;
      check("fast_valid", 64'(o_dump_valid), 64'd1);
      check("fast_addr",  64'(o_dump_addr),  64'(w));
      check("fast_data",  64'(o_dump_data),  64'(w * 32'h11));
      tick();
    end
    #1;
    check("fast_done",       64'(o_dump_done),  64'd1);
    check("fast_done_valid", 64'(o_dump_valid), 64'd0);
    tick();
    check("fast_done_once",  64'(o_dump_done),  64'd0);
    check("fast_idle_valid", 64'(o_dump_valid), 64'd0);
    tick();

    // Backpressure: ready alternates 0/1, 64 sending cycles, no loss or dup.
    i_dump_start = 1'b1;
    i_dump_ready = 1'b0;
    tick();
    i_dump_start = 1'b0;
    cyc = 0;
    k   = 0;
    while (cyc < 200) begin
      i_dump_ready = cyc[0];
      #1;
      if (o_dump_done) break;
      check("bp_valid", 64'(o_dump_valid), 64'd1);
      check("bp_addr",  64'(o_dump_addr),  64'(k));
      check("bp_data",  64'(o_dump_data),  64'(k * 32'h11));
      if (i_dump_ready) k++;
      cyc++;
      tick();
    end
    check("bp_done",   64'(o_dump_done), 64'd1);
    check("bp_cycles", 64'(cyc),         64'd64);
    check("bp_words",  64'(k),           64'd32);
    tick();

    // Writes during a dump: stalled word stays put, next word takes bypass.
    i_dump_start = 1'b1;
    i_dump_ready = 1'b1;
    tick();
    i_dump_start = 1'b0;
    #1;
    check("wr_addr0", 64'(o_dump_addr), 64'd0);
    tick();
    i_dump_ready = 1'b0;
    i_regwrite   = 1'b1;
    i_write_addr = 5'd1;
    i_write_data = 32'h5A5A5A5A;
    #1;
    check("wr_stall_addr", 64'(o_dump_addr), 64'd1);
    check("wr_stall_data", 64'(o_dump_data), 64'h11);
    tick();
    i_regwrite = 1'b0;
    #1;
    check("wr_stall_hold", 64'(o_dump_data), 64'h11);
    i_dump_ready = 1'b1;
    tick();
    i_regwrite   = 1'b1;
    i_write_addr = 5'd3;
    i_write_data = 32'hAAAA5555;
    #1;
    check("wr_addr2",   64'(o_dump_addr), 64'd2);
    check("wr_data2",   64'(o_dump_data), 64'h22);
    tick();
    i_regwrite    = 1'b0;
    i_read_addr_a = 5'd1;
    #1;
    check("wr_addr3",  64'(o_dump_addr), 64'd3);
    check("wr_data3",  64'(o_dump_data), 64'hAAAA5555);
    check("wr_r1_now", 64'(o_data_a),    64'h5A5A5A5A);
    n = 0;
    while (!o_dump_done && n < 100) begin
      tick();
      n++;
    end
    check("wr_done", 64'(o_dump_done), 64'd1);
    tick();

    // Reset in the middle of a dump aborts it and clears storage.
    i_dump_start = 1'b1;
    i_dump_ready = 1'b1;
    tick();
    i_dump_start = 1'b0;
    n = 0;
    while (o_dump_addr != 5'd10 && n < 100) begin
      tick();
      n++;
    end
    check("abort_at10", 64'(o_dump_addr), 64'd10);
    i_rst_n       = 1'b0;
    i_read_addr_a = 5'd5;
    i_read_addr_b = 5'd31;
    #1;
    check("abort_valid",  64'(o_dump_valid), 64'd0);
    check("abort_done",   64'(o_dump_done),  64'd0);
    check("abort_read_a", 64'(o_data_a),     64'd0);
    check("abort_read_b", 64'(o_data_b),     64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_no_done", 64'(o_dump_done), 64'd0);
    end
    i_rst_n = 1'b1;
    tick();
    i_dump_start = 1'b1;
    tick();
    i_dump_start = 1'b0;
    #1;
    check("restart_valid", 64'(o_dump_valid), 64'd1);
    check("restart_addr",  64'(o_dump_addr),  64'd0);
    check("restart_data",  64'(o_dump_data),  64'd0);
    n = 0;
    while (!o_dump_done && n < 100) begin
      tick();
      n++;
    end
    check("restart_done", 64'(o_dump_done), 64'd1);
    tick();

    // Randomized traffic: writes, reads, dumps and stalls interleaved; the
    // falling-edge model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      i_regwrite    = 1'($urandom_range(0, 1));
      i_write_addr  = AW'($urandom);
      i_write_data  = $urandom;
      i_read_addr_a = AW'($urandom);
      i_read_addr_b = AW'($urandom);
      i_dump_ready  = ($urandom_range(0, 3) != 0);
      i_dump_start  = ($urandom_range(0, 15) == 0);
      tick();
    end
    i_regwrite   = 1'b0;
    i_dump_start = 1'b0;
    i_dump_ready = 1'b1;
    repeat (40) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
